// File: rtl/subtrator_serial.sv
// rtl/subtrator_serial.sv - bit-serial unsigned subtractor, LSB first, WIDTH cycles per result
module subtrator_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             c
);

  localparam int CW = ($clog2(WIDTH + 1) < 1) ? 1 : $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  state_t           w_state_n;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] w_res_n;
  logic [WIDTH-1:0] r_s;
  logic             r_c;
  logic             r_bw;
  logic [CW-1:0]    r_cnt;
  logic             w_d;
  logic             w_bw_n;
  logic             w_last;
  logic             w_accept;

  assign w_d      = r_a[0] ^ r_b[0] ^ r_bw;
  assign w_bw_n   = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_bw);
  assign w_last   = (r_cnt == CW'(WIDTH - 1));
  assign w_accept = (r_state != RUN) && start;

  // Difference bits enter from the MSB so bit 0 ends up in s[0] after WIDTH shifts.
  generate
    if (WIDTH == 1) begin : g_w1
      assign w_res_n = w_d;
    end else begin : g_wn
      assign w_res_n = {w_d, r_res[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      IDLE:    if (start) w_state_n = RUN;
      RUN:     if (w_last) w_state_n = DONE;
      DONE:    w_state_n = start ? RUN : IDLE;
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_res <= '0;
      r_bw  <= 1'b0;
      r_cnt <= '0;
      r_s   <= '0;
      r_c   <= 1'b0;
    end else if (w_accept) begin
      r_a   <= a;
      r_b   <= b;
      r_res <= '0;
      r_bw  <= 1'b0;
      r_cnt <= '0;
    end else if (r_state == RUN) begin
      r_a   <= r_a >> 1;
      r_b   <= r_b >> 1;
      r_res <= w_res_n;
      r_bw  <= w_bw_n;
      r_cnt <= r_cnt + CW'(1);
      if (w_last) begin
        r_s <= w_res_n;
        r_c <= w_bw_n;
      end
    end
  end

  assign busy = (r_state == RUN);
  assign done = (r_state == DONE);
  assign s    = r_s;
  assign c    = r_c;

endmodule

// File: tb/tb_subtrator_serial.sv
// tb/tb_subtrator_serial.sv - scoreboard bench for subtrator_serial at WIDTH 1, 8 and 16
module tb_subtrator_serial;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        st1, st8, st16;
  logic [0:0]  a1, b1;
  logic [7:0]  a8, b8;
  logic [15:0] a16, b16;
  logic        busy1, done1, c1;
  logic        busy8, done8, c8;
  logic        busy16, done16, c16;
  logic [0:0]  s1;
  logic [7:0]  s8;
  logic [15:0] s16;

  always #5 clk = ~clk;

  subtrator_serial #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .start(st1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .s(s1), .c(c1)
  );
  subtrator_serial #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .start(st8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .s(s8), .c(c8)
  );
  subtrator_serial #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst(rst), .start(st16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .s(s16), .c(c16)
  );

  typedef struct {
    logic [15:0] s;
    logic        c;
    int          acc;
  } exp_t;

  exp_t q1[$];
  exp_t q8[$];
  exp_t q16[$];

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int nd1 = 0, nd8 = 0, nd16 = 0;
  int d8_prev = 0, d8_last = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b);
    exp_t        e;
    logic [16:0] mask;
    mask  = (17'd1 << w) - 17'd1;
    e.s   = (a - b) & mask[15:0];
    e.c   = ((a & mask[15:0]) < (b & mask[15:0]));
    e.acc = 0;
    return e;
  endfunction

  always @(negedge clk) begin : mon1
    exp_t e;
    if (!rst && done1) begin
      nd1++;
      chk("w1_busy_at_done", busy1, 0);
      if (q1.size() == 0) chk("w1_spurious_done", 1, 0);
      else begin
        e = q1.pop_front();
        chk("w1_s", s1, e.s);
        chk("w1_c", c1, e.c);
        chk("w1_latency", cyc - e.acc, 1);
      end
    end
  end

  always @(negedge clk) begin : mon8
    exp_t e;
    if (!rst && done8) begin
      nd8++;
      d8_prev = d8_last;
      d8_last = cyc;
      chk("w8_busy_at_done", busy8, 0);
      if (q8.size() == 0) chk("w8_spurious_done", 1, 0);
      else begin
        e = q8.pop_front();
        chk("w8_s", s8, e.s);
        chk("w8_c", c8, e.c);
        chk("w8_latency", cyc - e.acc, 8);
      end
    end
  end

  always @(negedge clk) begin : mon16
    exp_t e;
    if (!rst && done16) begin
      nd16++;
      chk("w16_busy_at_done", busy16, 0);
      if (q16.size() == 0) chk("w16_spurious_done", 1, 0);
      else begin
        e = q16.pop_front();
        chk("w16_s", s16, e.s);
        chk("w16_c", c16, e.c);
        chk("w16_latency", cyc - e.acc, 16);
      end
    end
  end

  function automatic int qsize(input int w);
    case (w)
      1:       return q1.size();
      8:       return q8.size();
      default: return q16.size();
    endcase
  endfunction

  // Caller is at a negedge; the coming posedge is the accepting edge numbered acc.
  task automatic issue(input int w, input logic [15:0] a, input logic [15:0] b,
                       input bit track, input int acc);
    exp_t e;
    e = model(w, a, b);
    e.acc = acc;
    case (w)
      1: begin a1 = a[0:0]; b1 = b[0:0]; st1 = 1'b1; if (track) q1.push_back(e); end
      8: begin a8 = a[7:0]; b8 = b[7:0]; st8 = 1'b1; if (track) q8.push_back(e); end
      default: begin a16 = a; b16 = b; st16 = 1'b1; if (track) q16.push_back(e); end
    endcase
  endtask

  task automatic drop();
    st1 = 1'b0;
    st8 = 1'b0;
    st16 = 1'b0;
    a8 = 8'h00;
    b8 = 8'h00;
  endtask

  task automatic wait_empty(input int w, input string tag);
    int n;
    n = 0;
    while (qsize(w) != 0 && n < 60) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (qsize(w) != 0) chk({tag, "_timeout"}, 1, 0);
  endtask

  task automatic run_op(input int w, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    issue(w, a, b, 1'b1, cyc + 1);
    @(negedge clk);
    drop();
    wait_empty(w, "op");
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [7:0] ta [4] = '{8'h05, 8'h03, 8'h00, 8'hA5};
  logic [7:0] tb [4] = '{8'h03, 8'h05, 8'hFF, 8'hA5};

  initial begin : main
    int n0;
    int acc1;
    st1 = 1'b0; st8 = 1'b0; st16 = 1'b0;
    a1 = '0; b1 = '0; a8 = '0; b8 = '0; a16 = '0; b16 = '0;
    #1;
    chk("rst_busy8", busy8, 0);
    chk("rst_done8", done8, 0);
    chk("rst_s8", s8, 0);
    chk("rst_c8", c8, 0);
    chk("rst_s1", s1, 0);
    chk("rst_s16", s16, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) run_op(1, 16'(i >> 1), 16'(i & 1));

    for (int i = 0; i < 4; i++) run_op(8, {8'h00, ta[i]}, {8'h00, tb[i]});

    // Second start during RUN must be dropped entirely.
    n0 = nd8;
    @(negedge clk);
    issue(8, 16'h0010, 16'h0001, 1'b1, cyc + 1);
    @(negedge clk);
    drop();
    repeat (2) @(negedge clk);
    issue(8, 16'h0000, 16'h0001, 1'b0, 0);
    @(negedge clk);
    drop();
    wait_empty(8, "ignore");
    repeat (12) @(negedge clk);
    chk("ignore_single_done", nd8 - n0, 1);

    @(negedge clk);
    issue(8, 16'h003C, 16'h0011, 1'b1, cyc + 1);
    @(negedge clk);
    drop();
    repeat (3) @(negedge clk);
    #2;
    chk("busy_before_rst", busy8, 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_busy", busy8, 0);
    chk("rst_mid_done", done8, 0);
    chk("rst_mid_s", s8, 0);
    chk("rst_mid_c", c8, 0);
    q8.delete();
    n0 = nd8;
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("rst_no_done", nd8 - n0, 0);
    run_op(8, 16'h003C, 16'h0011);

    @(negedge clk);
    acc1 = cyc + 1;
    issue(8, 16'h0080, 16'h0001, 1'b1, acc1);
    @(negedge clk);
    issue(8, 16'h0001, 16'h0002, 1'b1, acc1 + 9);
    while (cyc < acc1 + 9) @(negedge clk);
    drop();
    wait_empty(8, "b2b");
    chk("b2b_spacing", d8_last - d8_prev, 9);

    n0 = nd16;
    for (int i = 0; i < 1000; i++) run_op(16, 16'($urandom), 16'($urandom));
    chk("w16_done_count", nd16 - n0, 1000);

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
